tf_expgen: RTL and testbench

TF_EXPGEN -- requirements
Module: tf_expgen

---
 rtl/tf_expgen.sv | 143 ++++++++++++++
 tb/tb_tf_expgen.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tf_expgen.sv
// tf_expgen: twiddle exponent (ROM address) generator for a 512-point FFT,
// four butterfly lanes per cycle, 64 groups per stage, NSTAGE stages per frame.
// Build macro TF_EXPGEN_DIT_EN selects DIT exponent order; default build is DIF.

module tf_expgen #(
  parameter int NSTAGE = 9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       HOLD,
  output logic [7:0] EXP0,
  output logic [7:0] EXP1,
  output logic [7:0] EXP2,
  output logic [7:0] EXP3,
  output logic       VALID,
  output logic       TF_VALID,
  output logic [3:0] STAGE,
  output logic       LAST,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STG = 4'(NSTAGE - 1);

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [3:0]      stg_q, stg_d;
  logic [3:0][7:0] exp_q, exp_d;
  logic            valid_q, valid_d;
  logic            tf_valid_q, tf_valid_d;
  logic [3:0]      stage_q, stage_d;
  logic            last_q, last_d;
  logic            done_q, done_d;
  logic            last_group;

  // Exponent of one lane: butterfly index j = 4*cnt + lane, masked and shifted by stage.
  function automatic logic [7:0] lane_exp(input logic [5:0] cnt,
                                          input logic [1:0] lane,
                                          input logic [3:0] stg);
    logic [7:0] j;
    logic [7:0] mask;
    j = {cnt, lane};
`ifdef TF_EXPGEN_DIT_EN
    mask = ~(8'hFF << stg);
    return (j & mask) << (4'd8 - stg);
`else
    mask = 8'hFF >> stg;
    return (j & mask) << stg;
`endif
  endfunction

  assign last_group = (cnt_q == 6'd63) && (stg_q == LAST_STG);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stg_d      = stg_q;
    exp_d      = exp_q;
    valid_d    = 1'b0;
    tf_valid_d = valid_q;
    stage_d    = stage_q;
    last_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
          cnt_d   = 6'd0;
          stg_d   = 4'd0;
        end
      end
      RUN: begin
        if (!HOLD) begin
          valid_d = 1'b1;
          stage_d = stg_q;
          last_d  = last_group;
          for (int l = 0; l < 4; l++) begin
            exp_d[l] = lane_exp(cnt_q, 2'(l), stg_q);
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            if (last_group) begin
              stg_d   = 4'd0;
              state_d = FIN;
            end else begin
              stg_d = stg_q + 4'd1;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stg_q      <= '0;
      exp_q      <= '0;
      valid_q    <= 1'b0;
      tf_valid_q <= 1'b0;
      stage_q    <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stg_q      <= stg_d;
      exp_q      <= exp_d;
      valid_q    <= valid_d;
      tf_valid_q <= tf_valid_d;
      stage_q    <= stage_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign EXP0     = exp_q[0];
  assign EXP1     = exp_q[1];
  assign EXP2     = exp_q[2];
  assign EXP3     = exp_q[3];
  assign VALID    = valid_q;
  assign TF_VALID = tf_valid_q;
  assign STAGE    = stage_q;
  assign LAST     = last_q;
  assign BUSY     = (state_q == RUN);
  assign DONE     = done_q;

endmodule

// File: tb/tb_tf_expgen.sv
// Self-checking bench for tf_expgen: scoreboard of expected exponent groups per frame.

module tb_tf_expgen;

  localparam int NSTAGE = 9;
  localparam int NGROUP = 64 * NSTAGE;

  logic       CLK = 1'b0;
  logic       RST, START, HOLD;
  logic [7:0] EXP0, EXP1, EXP2, EXP3;
  logic       VALID, TF_VALID, LAST, BUSY, DONE;
  logic [3:0] STAGE;
  logic [3:0][7:0] dut_exp;

  typedef struct packed {
    logic [3:0][7:0] e;
    logic [3:0]      stage;
    logic            last;
  } grp_t;

  grp_t            sb[$];
  int              checks = 0;
  int              failures = 0;
  logic [3:0][7:0] last_exp = '0;
  logic            prev_valid = 1'b0;

  assign dut_exp = {EXP3, EXP2, EXP1, EXP0};

  tf_expgen #(.NSTAGE(NSTAGE)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD),
    .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3),
    .VALID(VALID), .TF_VALID(TF_VALID), .STAGE(STAGE),
    .LAST(LAST), .BUSY(BUSY), .DONE(DONE)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Reference exponent straight from the exponent formulas.
  function automatic logic [7:0] model_exp(input int g, input int l, input int s);
    int j;
    int r;
    j = 4 * g + l;
`ifdef TF_EXPGEN_DIT_EN
    r = (j & ((1 << s) - 1)) << (8 - s);
`else
    r = (j & ((256 >> s) - 1)) << s;
`endif
    return r[7:0];
  endfunction

  task automatic push_frame();
    grp_t x;
    for (int s = 0; s < NSTAGE; s++) begin
      for (int g = 0; g < 64; g++) begin
        for (int l = 0; l < 4; l++) x.e[l] = model_exp(g, l, s);
        x.stage = 4'(s);
        x.last  = (s == NSTAGE - 1) && (g == 63);
        sb.push_back(x);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; HOLD = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({dut_exp, VALID, TF_VALID, STAGE, LAST, BUSY, DONE} !== 42'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got exp=%h v=%b tv=%b st=%0d last=%b busy=%b done=%b want all zero",
               dut_exp, VALID, TF_VALID, STAGE, LAST, BUSY, DONE);
    end
    RST = 1'b0;
    prev_valid = 1'b0;
    last_exp = '0;
  endtask

  task automatic test_full_frame(input bit poke_start);
    int   cyc = 0;
    int   nvalid = 0;
    int   last_cyc = -10;
    bit   done_seen = 1'b0;
    grp_t g;
    push_frame();
    START = 1'b1; HOLD = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      checks++;
      if (TF_VALID !== prev_valid) begin
        failures++;
        $display("[TB] FAIL tf_valid cyc=%0d got=%b want=%b", cyc, TF_VALID, prev_valid);
      end
      prev_valid = VALID;
      if (VALID === 1'b1) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL extra_group cyc=%0d got VALID=1 want no more groups", cyc);
        end else begin
          g = sb.pop_front();
          if ({dut_exp, STAGE, LAST} !== {g.e, g.stage, g.last}) begin
            failures++;
            $display("[TB] FAIL group n=%0d got exp=%h st=%0d last=%b want exp=%h st=%0d last=%b",
                     nvalid, dut_exp, STAGE, LAST, g.e, g.stage, g.last);
          end
          last_exp = g.e;
        end
        if (LAST !== 1'b1) begin
          checks++;
          if (BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL busy n=%0d got=%b want=1", nvalid, BUSY);
          end
        end
      end else begin
        checks++;
        if (dut_exp !== last_exp || LAST !== 1'b0) begin
          failures++;
          $display("[TB] FAIL freeze cyc=%0d got exp=%h last=%b want exp=%h last=0",
                   cyc, dut_exp, LAST, last_exp);
        end
      end
      if (LAST === 1'b1) last_cyc = cyc;
      if (DONE === 1'b1) begin
        done_seen = 1'b1;
        checks++;
        if (cyc != last_cyc + 1 || BUSY !== 1'b0) begin
          failures++;
          $display("[TB] FAIL done_timing got cyc=%0d busy=%b want cyc=%0d busy=0", cyc, BUSY, last_cyc + 1);
        end
      end
      START = poke_start && (nvalid == 100 || nvalid == 300 || LAST === 1'b1);
    end
    START = 1'b0;
    checks++;
    if (!done_seen) begin
      failures++;
      $display("[TB] FAIL done_timeout got no DONE in %0d cycles want DONE", cyc);
    end
    checks++;
    if (nvalid != NGROUP) begin
      failures++;
      $display("[TB] FAIL valid_count got=%0d want=%0d", nvalid, NGROUP);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL leftover got=%0d groups unissued want=0", sb.size());
    end
    @(negedge CLK);
    checks++;
    if ({DONE, BUSY, VALID} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL done_pulse got done=%b busy=%b valid=%b want 0 0 0", DONE, BUSY, VALID);
    end
    prev_valid = VALID;
    sb.delete();
  endtask

  task automatic test_hold();
    int   cyc = 0;
    int   nvalid = 0;
    int   hold_left = 2;
    int   target_left = 0;
    bit   hold_prev = 1'b1;
    bit   last_seen = 1'b0;
    bit   done_seen = 1'b0;
    grp_t g;
    logic [3:0][7:0] frozen;
`ifndef TF_EXPGEN_DIT_EN
    frozen = {8'd172, 8'd168, 8'd164, 8'd160};
`else
    for (int l = 0; l < 4; l++) frozen[l] = model_exp(10, l, 2);
`endif
    push_frame();
    START = 1'b1; HOLD = 1'b1;
    while (!done_seen && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      checks++;
      if (TF_VALID !== prev_valid) begin
        failures++;
        $display("[TB] FAIL tf_valid cyc=%0d got=%b want=%b", cyc, TF_VALID, prev_valid);
      end
      prev_valid = VALID;
      if (cyc >= 2 && !last_seen) begin
        checks++;
        if (VALID !== (hold_prev ? 1'b0 : 1'b1)) begin
          failures++;
          $display("[TB] FAIL hold_valid cyc=%0d got=%b want=%b", cyc, VALID, !hold_prev);
        end
      end
      if (VALID === 1'b1) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL extra_group cyc=%0d got VALID=1 want no more groups", cyc);
        end else begin
          g = sb.pop_front();
          if ({dut_exp, STAGE, LAST} !== {g.e, g.stage, g.last}) begin
            failures++;
            $display("[TB] FAIL group n=%0d got exp=%h st=%0d last=%b want exp=%h st=%0d last=%b",
                     nvalid, dut_exp, STAGE, LAST, g.e, g.stage, g.last);
          end
          last_exp = g.e;
        end
      end else begin
        checks++;
        if (dut_exp !== last_exp || LAST !== 1'b0) begin
          failures++;
          $display("[TB] FAIL freeze cyc=%0d got exp=%h last=%b want exp=%h last=0",
                   cyc, dut_exp, LAST, last_exp);
        end
      end
      if (target_left > 0) begin
        checks++;
        if (dut_exp !== frozen || VALID !== 1'b0 || STAGE !== 4'd2) begin
          failures++;
          $display("[TB] FAIL hold_target got exp=%h v=%b st=%0d want exp=%h v=0 st=2",
                   dut_exp, VALID, STAGE, frozen);
        end
        target_left--;
      end
      if (LAST === 1'b1) last_seen = 1'b1;
      if (DONE === 1'b1) done_seen = 1'b1;
      START = 1'b0;
      if (VALID === 1'b1 && nvalid == 2 * 64 + 11) begin
        hold_left = 5;
        target_left = 5;
      end
      if (hold_left > 0) begin
        HOLD = 1'b1;
        hold_left--;
      end else if (nvalid > 2 * 64 + 11 && !last_seen) begin
        HOLD = ($urandom_range(0, 5) == 0);
      end else begin
        HOLD = 1'b0;
      end
      hold_prev = HOLD;
    end
    HOLD = 1'b0;
    checks++;
    if (!done_seen || nvalid != NGROUP || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL hold_frame got done=%b valid=%0d left=%0d want done=1 valid=%0d left=0",
               done_seen, nvalid, sb.size(), NGROUP);
    end
    sb.delete();
  endtask

  task automatic test_reset_abort();
    int   cyc = 0;
    int   nvalid = 0;
    grp_t g;
    push_frame();
    START = 1'b1; HOLD = 1'b0;
    while (nvalid < 4 * 64 + 21 && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      prev_valid = VALID;
      if (VALID === 1'b1 && sb.size() != 0) begin
        nvalid++;
        g = sb.pop_front();
        checks++;
        if ({dut_exp, STAGE, LAST} !== {g.e, g.stage, g.last}) begin
          failures++;
          $display("[TB] FAIL abort_group n=%0d got exp=%h st=%0d want exp=%h st=%0d",
                   nvalid, dut_exp, STAGE, g.e, g.stage);
        end
      end
    end
    checks++;
    if (nvalid != 4 * 64 + 21) begin
      failures++;
      $display("[TB] FAIL abort_reach got=%0d groups want=%0d", nvalid, 4 * 64 + 21);
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({dut_exp, VALID, TF_VALID, STAGE, LAST, BUSY, DONE} !== 42'd0) begin
      failures++;
      $display("[TB] FAIL abort_state got exp=%h v=%b tv=%b st=%0d last=%b busy=%b done=%b want all zero",
               dut_exp, VALID, TF_VALID, STAGE, LAST, BUSY, DONE);
    end
    RST = 1'b0;
    sb.delete();
    last_exp = '0;
    prev_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if ({VALID, BUSY, DONE} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL abort_quiet i=%0d got v=%b busy=%b done=%b want 0 0 0", i, VALID, BUSY, DONE);
      end
    end
  endtask

  // Test sequence.
  initial begin
    RST = 1'b1; START = 1'b0; HOLD = 1'b0;
    test_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_hold();
    test_reset_abort();
    test_full_frame(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
